muldiv_sequencer: RTL

//  Controller for a multi-cycle iterative multiply/divide resource attached to the execute stage (RV32M).

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_iter_core.sv | 65 ++++++
 rtl/muldiv_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer:
// funct3 op encodings, FSM state type and small op-classification helpers.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // rs1 is sign-interpreted by MUL, MULH, MULHSU, DIV and REM
    function automatic logic op_rs1_signed(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_rs2_signed(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on
// unsigned magnitudes. {hi,lo} holds the product, or remainder/quotient.
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
        ge      = (shifted >= {1'b0, b_q});
        if (load_i) begin
            hi_d = '0;
            lo_d = a_i;
            b_d  = b_i;
        end else if (step_i) begin
            if (is_div_i) begin
                // a zero divisor always "fits", giving all-ones quotient and rem = dividend
                hi_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], ge};
            end else begin
                {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            b_q  <= b_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide controller: FSM, iteration counter, sign
// handling and pipeline stall. Define MULDIV_EARLY_OUT_EN for the trivial-operand shortcut.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    input  logic [4:0]       rd_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             result_valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       rd_o
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2:0]         op_q, op_d;
    logic [4:0]         rd_q, rd_d;
    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [4:0]         rd_out_q, rd_out_d;
    logic               valid_q, valid_d;

    logic               accept;
    logic               load;
    logic               s1_in, s2_in;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   core_hi, core_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, sel;

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .step_i   (state_q == CALC),
        .is_div_i (op_is_div(op_q)),
        .a_i      (a_mag),
        .b_i      (b_mag),
        .hi_o     (core_hi),
        .lo_o     (core_lo)
    );

    assign accept = start_i & ~flush_i;
    assign s1_in  = op_rs1_signed(op_i) & rs1_i[WIDTH-1];
    assign s2_in  = op_rs2_signed(op_i) & rs2_i[WIDTH-1];
    assign a_mag  = s1_in ? -rs1_i : rs1_i;
    assign b_mag  = s2_in ? -rs2_i : rs2_i;

    assign prod     = {core_hi, core_lo};
    assign prod_fix = (s1_q ^ s2_q) ? -prod : prod;
    assign quot_fix = dz_q ? '1 : ((s1_q ^ s2_q) ? -core_lo : core_lo);
    assign rem_fix  = s1_q ? -core_hi : core_hi;

    always_comb begin
        case (op_q)
            OP_MUL:          sel = prod_fix[WIDTH-1:0];
            OP_DIV, OP_DIVU: sel = quot_fix;
            OP_REM, OP_REMU: sel = rem_fix;
            default:         sel = prod_fix[2*WIDTH-1:WIDTH];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        rd_d     = rd_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        dz_d     = dz_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        valid_d  = 1'b0;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    op_d    = op_i;
                    rd_d    = rd_i;
                    s1_d    = s1_in;
                    s2_d    = s2_in;
                    dz_d    = (rs2_i == '0);
                    count_d = '0;
                    state_d = CALC;
`ifdef MULDIV_EARLY_OUT_EN
                    if ((rs2_i == '0) || (!op_is_div(op_i) && (rs1_i == '0))) begin
                        state_d  = DONE;
                        valid_d  = 1'b1;
                        rd_out_d = rd_i;
                        result_d = !op_is_div(op_i) ? '0 : (op_i[1] ? rs1_i : '1);
                    end
`endif
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    count_d = count_q + 1'b1;
                    if (count_q == CNT_W'(WIDTH - 1)) state_d = FIXUP;
                end
            end
            FIXUP: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    result_d = sel;
                    rd_out_d = rd_q;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            dz_q     <= dz_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
            valid_q  <= valid_d;
        end
    end

    // a flush landing in DONE still withdraws the pulse
    assign result_valid_o = valid_q & ~flush_i;
    assign stall_o        = ((state_q == IDLE) & accept) | (state_q == CALC) | (state_q == FIXUP);
    assign busy_o         = (state_q != IDLE);
    assign result_o       = result_q;
    assign rd_o           = rd_out_q;

endmodule
